// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned PORT0 = 0;
    localparam int unsigned PORT1 = 1;
    localparam int unsigned IDX_W = 10;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie, the port not served last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // last == 1 means port 1 was served most recently, so port 0 wins a tie.
    always_comb begin
        pick        = 2'b00;
        pick[PORT0] = req[PORT0] & (~req[PORT1] | last);
        pick[PORT1] = req[PORT1] & (~req[PORT0] | ~last);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port 1024x32 data memory, round-robin with lock.
// Optional conflict counter enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned IDX_W = dmem_arb_pkg::IDX_W
) (
    input  logic          clk,
    input  logic          reset,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]   conflict_cnt,
`endif
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    if (AW < IDX_W) begin : g_aw_check
        $error("dmem_arbiter: AW must cover the memory index width");
    end

    arb_state_e state_q;
    logic       last_q;
    logic [1:0] req_vec;
    logic [1:0] pick;
    logic [1:0] gnt_vec;

    assign req_vec = {req1, req0};

    rr_pick2 u_pick (
        .req  (req_vec),
        .last (last_q),
        .pick (pick)
    );

    // While owned, only the owner can be granted; reset suppresses every grant.
    always_comb begin
        gnt_vec = 2'b00;
        if (!reset) begin
            unique case (state_q)
                IDLE:    gnt_vec = pick;
                OWN0:    gnt_vec[PORT0] = req0;
                OWN1:    gnt_vec[PORT1] = req1;
                default: gnt_vec = 2'b00;
            endcase
        end
    end

    assign gnt0 = gnt_vec[PORT0];
    assign gnt1 = gnt_vec[PORT1];

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (gnt0) begin
            mem_read  = ~we0;
            mem_write = we0;
            mem_addr  = addr0;
            mem_din   = wdata0;
        end else if (gnt1) begin
            mem_read  = ~we1;
            mem_write = we1;
            mem_addr  = addr1;
            mem_din   = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= mem_dout;
            if (gnt1 && !we1) rdata1 <= mem_dout;

            if (gnt0) begin
                state_q <= lock0 ? OWN0 : IDLE;
                last_q  <= 1'b0;
            end else if (gnt1) begin
                state_q <= lock1 ? OWN1 : IDLE;
                last_q  <= 1'b1;
            end else if ((state_q == OWN0 && !req0) || (state_q == OWN1 && !req1)) begin
                // Owner dropped its request for a cycle: release the lock.
                state_q <= IDLE;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic conflict;

    assign conflict = (req0 & ~gnt0) | (req1 & ~gnt1);

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (conflict && !(&conflict_cnt)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
